// File: rtl/ysyx_25010008_bus_pkg.sv
// Shared bus definitions for the crossbar and its slaves (SRAM, UART, CLINT).
// Holds the 1-bit response codes, the CLINT base address and the state
// encodings of the slave-side read and write channel FSMs.
package ysyx_25010008_bus_pkg;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    // Address of mtime[31:0]; mtime[63:32] sits at the next word.
    localparam logic [31:0] CLINT_BASE_ADDR = 32'ha000_0048;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    // Expand a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/ysyx_25010008_clint_timer.sv
// Free-running 64-bit machine timer with a clock prescaler and a bit-masked
// load port.
//   clk, rst   : clock, synchronous active-high reset (clears everything)
//   load_en    : replace the masked bits of mtime with load_data this cycle
//   load_mask  : 1 = take the bit from load_data
//   load_data  : value to merge into mtime
//   mtime      : current counter value (registered)
module ysyx_25010008_clint_timer #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [63:0] load_mask,
    input  logic [63:0] load_data,
    output logic [63:0] mtime
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic          wrap;

    assign wrap = (presc == PRE_MAX);

    // A load wins over the tick in the same cycle and restarts the prescaler,
    // so the loaded value is held for a full TICK_DIV period.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            mtime <= '0;
        end else if (load_en) begin
            presc <= '0;
            mtime <= (mtime & ~load_mask) | (load_data & load_mask);
        end else begin
            presc <= wrap ? '0 : presc + PW'(1);
            if (wrap) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

endmodule

// File: rtl/ysyx_25010008_clint.sv
// CLINT mtime slave on the crossbar's AXI-lite-style channels (1-bit resp).
//   clk, rst                  : clock, synchronous active-high reset
//   araddr/arvalid/arready    : read address channel
//   rdata/rresp/rvalid/rready : read data channel
//   awaddr/awvalid/awready    : write address channel
//   wdata/wstrb/wvalid/wready : write data channel (only wstrb[3:0] used)
//   bresp/bvalid/bready       : write response channel
// Reading the low word snapshots the high word so a low-then-high read pair
// is atomic. Byte-strobed writes preset the counter; any other address
// answers with an error response.
module ysyx_25010008_clint
    import ysyx_25010008_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = CLINT_BASE_ADDR,
    parameter int          TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic        rresp,
    output logic        rvalid,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [31:0] wstrb,
    input  logic        wvalid,
    output logic        wready,
    input  logic        bready,
    output logic        bresp,
    output logic        bvalid
);

    localparam logic [31:0] HI_ADDR = BASE_ADDR + 32'd4;

    logic [63:0] mtime;
    logic        load_en;
    logic [63:0] load_mask;
    logic [63:0] load_data;

    logic unused_wstrb;
    assign unused_wstrb = ^wstrb[31:4];

    ysyx_25010008_clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_mask (load_mask),
        .load_data (load_data),
        .mtime     (mtime)
    );

    // ---------------- read channel ----------------
    r_state_t    r_state, r_state_nxt;
    logic [31:0] rdata_nxt;
    logic        rresp_nxt;
    logic [31:0] hi_snap, hi_snap_nxt;

    always_comb begin
        r_state_nxt = r_state;
        rdata_nxt   = rdata;
        rresp_nxt   = rresp;
        hi_snap_nxt = hi_snap;
        case (r_state)
            R_IDLE: begin
                if (arvalid) begin
                    r_state_nxt = R_RESP;
                    if (araddr == BASE_ADDR) begin
                        rdata_nxt   = mtime[31:0];
                        rresp_nxt   = RESP_OKAY;
                        hi_snap_nxt = mtime[63:32];
                    end else if (araddr == HI_ADDR) begin
                        rdata_nxt = hi_snap;
                        rresp_nxt = RESP_OKAY;
                    end else begin
                        rdata_nxt = 32'd0;
                        rresp_nxt = RESP_ERR;
                    end
                end
            end
            R_RESP: begin
                if (rready) begin
                    r_state_nxt = R_IDLE;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            rdata   <= 32'd0;
            rresp   <= RESP_OKAY;
            hi_snap <= 32'd0;
        end else begin
            r_state <= r_state_nxt;
            rdata   <= rdata_nxt;
            rresp   <= rresp_nxt;
            hi_snap <= hi_snap_nxt;
        end
    end

    assign arready = (r_state == R_IDLE);
    assign rvalid  = (r_state == R_RESP);

    // ---------------- write channel ----------------
    w_state_t    w_state, w_state_nxt;
    logic [31:0] awaddr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        awready_nxt, wready_nxt, bvalid_nxt, bresp_nxt;
    logic        aw_hs, w_hs, commit;
    logic [31:0] eff_addr, eff_data;
    logic [3:0]  eff_strb;
    logic        addr_lo, addr_hi;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // A beat is either arriving now (ready still high) or already held.
    assign eff_addr = awready ? awaddr     : awaddr_q;
    assign eff_data = wready  ? wdata      : wdata_q;
    assign eff_strb = wready  ? wstrb[3:0] : wstrb_q;

    assign addr_lo = (eff_addr == BASE_ADDR);
    assign addr_hi = (eff_addr == HI_ADDR);

    assign commit = (w_state != W_RESP) && (aw_hs || !awready) && (w_hs || !wready);

    assign load_en   = commit && (addr_lo || addr_hi);
    assign load_mask = addr_hi ? {strb_to_mask(eff_strb), 32'd0}
                               : {32'd0, strb_to_mask(eff_strb)};
    assign load_data = {eff_data, eff_data};

    always_comb begin
        w_state_nxt = w_state;
        awready_nxt = awready;
        wready_nxt  = wready;
        bvalid_nxt  = bvalid;
        bresp_nxt   = bresp;
        case (w_state)
            W_IDLE, W_WAIT: begin
                awready_nxt = awready && !aw_hs;
                wready_nxt  = wready && !w_hs;
                if (commit) begin
                    w_state_nxt = W_RESP;
                    bvalid_nxt  = 1'b1;
                    bresp_nxt   = (addr_lo || addr_hi) ? RESP_OKAY : RESP_ERR;
                end else if (!awready_nxt || !wready_nxt) begin
                    w_state_nxt = W_WAIT;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_nxt = W_IDLE;
                    awready_nxt = 1'b1;
                    wready_nxt  = 1'b1;
                    bvalid_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = W_IDLE;
                awready_nxt = 1'b1;
                wready_nxt  = 1'b1;
                bvalid_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            awready <= 1'b1;
            wready  <= 1'b1;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            w_state <= w_state_nxt;
            awready <= awready_nxt;
            wready  <= wready_nxt;
            bvalid  <= bvalid_nxt;
            bresp   <= bresp_nxt;
        end
    end

    // Beat holding registers carry data only.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            awaddr_q <= awaddr;
        end
        if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb[3:0];
        end
    end

endmodule
